// File: rtl/control_unit_pkg.sv
// Shared types and constants for the calculator-CPU control sequencer:
// state and opcode-class encodings, opcode map, address-mux codes, strobe decode.
package control_unit_pkg;

    localparam int unsigned OPC_W      = 6;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned ADDR_SEL_W = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_IRLOAD,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_ALU_WAIT,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_HLT,
        CLS_LDR,
        CLS_STR,
        CLS_PSH,
        CLS_POP,
        CLS_BRANCH,
        CLS_ALU,
        CLS_NOP
    } class_e;

    localparam logic [OPC_W-1:0] OPC_HLT      = 6'h00;
    localparam logic [OPC_W-1:0] OPC_LDR      = 6'h01;
    localparam logic [OPC_W-1:0] OPC_STR      = 6'h02;
    localparam logic [OPC_W-1:0] OPC_PSH      = 6'h03;
    localparam logic [OPC_W-1:0] OPC_POP      = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BRZ      = 6'h05;
    localparam logic [OPC_W-1:0] OPC_BRN      = 6'h06;
    localparam logic [OPC_W-1:0] OPC_BRC      = 6'h07;
    localparam logic [OPC_W-1:0] OPC_BRV      = 6'h08;
    localparam logic [OPC_W-1:0] OPC_BRA      = 6'h09;
    localparam logic [OPC_W-1:0] OPC_ALU_BASE = 6'h10;

    localparam logic [ADDR_SEL_W-1:0] ADDR_PC  = 2'd0;
    localparam logic [ADDR_SEL_W-1:0] ADDR_IMM = 2'd1;
    localparam logic [ADDR_SEL_W-1:0] ADDR_SP  = 2'd2;

    // Branch condition index into FLAGS = {Z,N,C,V}
    localparam logic [1:0] COND_Z = 2'd0;
    localparam logic [1:0] COND_N = 2'd1;
    localparam logic [1:0] COND_C = 2'd2;
    localparam logic [1:0] COND_V = 2'd3;

    typedef struct packed {
        logic                  ir_w;
        logic                  pc_inc;
        logic [ADDR_SEL_W-1:0] addr_sel;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  sp_inc;
        logic                  sp_dec;
        logic                  alu_start;
        logic                  reg_w;
        logic                  wb_sel;
        logic                  illegal;
    } strobe_t;

    function automatic logic flag_sel(logic [FLAG_W-1:0] flags, logic [1:0] idx);
        logic f;
        case (idx)
            COND_Z:  f = flags[3];
            COND_N:  f = flags[2];
            COND_C:  f = flags[1];
            default: f = flags[0];
        endcase
        return f;
    endfunction

    // Moore strobe pattern for a state given the latched opcode class
    function automatic strobe_t decode_strobes(state_e st, class_e cls, logic illegal);
        strobe_t s;
        s = '0;
        case (st)
            ST_FETCH: begin
                s.mem_rd   = 1'b1;
                s.addr_sel = ADDR_PC;
            end
            ST_IRLOAD: begin
                s.ir_w   = 1'b1;
                s.pc_inc = 1'b1;
            end
            ST_EXEC: begin
                s.alu_start = (cls == CLS_ALU);
                s.sp_dec    = (cls == CLS_PSH);
                s.illegal   = illegal;
            end
            ST_MEM: begin
                s.addr_sel = (cls == CLS_PSH || cls == CLS_POP) ? ADDR_SP : ADDR_IMM;
                s.mem_rd   = (cls == CLS_LDR || cls == CLS_POP);
                s.mem_wr   = (cls == CLS_STR || cls == CLS_PSH);
            end
            ST_WB: begin
                s.reg_w  = 1'b1;
                s.wb_sel = (cls == CLS_LDR || cls == CLS_POP);
                s.sp_inc = (cls == CLS_POP);
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction/status inputs and control strobes between the sequencer and the datapath.
interface control_unit_if;
    import control_unit_pkg::*;

    logic                  start;
    logic [OPC_W-1:0]      opcode;
    logic [FLAG_W-1:0]     flags;
    logic                  mem_ready;
    logic                  alu_done;

    logic                  ir_w;
    logic                  pc_inc;
    logic                  pc_load_c;
    logic [ADDR_SEL_W-1:0] addr_sel;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  sp_inc;
    logic                  sp_dec;
    logic                  alu_start;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  reg_w;
    logic                  wb_sel;
    logic                  illegal;
    logic                  halted;
    logic                  fault;

    modport slave (
        input  start, opcode, flags, mem_ready, alu_done,
        output ir_w, pc_inc, pc_load_c, addr_sel, mem_rd, mem_wr, sp_inc, sp_dec,
               alu_start, alu_op, reg_w, wb_sel, illegal, halted, fault
    );

    modport master (
        output start, opcode, flags, mem_ready, alu_done,
        input  ir_w, pc_inc, pc_load_c, addr_sel, mem_rd, mem_wr, sp_inc, sp_dec,
               alu_start, alu_op, reg_w, wb_sel, illegal, halted, fault
    );
endinterface

// File: rtl/control_unit_opcode_classifier.sv
// Combinational opcode decode: instruction class, branch condition index, illegal flag.
module control_unit_opcode_classifier
    import control_unit_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output class_e           o_class,
    output logic [1:0]       o_cond_idx,
    output logic             o_cond_always,
    output logic             o_illegal
);

    always_comb begin
        o_class       = CLS_NOP;
        o_cond_idx    = COND_Z;
        o_cond_always = 1'b0;
        o_illegal     = 1'b0;
        if (i_opcode[5:4] == OPC_ALU_BASE[5:4]) begin
            o_class = CLS_ALU;
        end else begin
            case (i_opcode)
                OPC_HLT: o_class = CLS_HLT;
                OPC_LDR: o_class = CLS_LDR;
                OPC_STR: o_class = CLS_STR;
                OPC_PSH: o_class = CLS_PSH;
                OPC_POP: o_class = CLS_POP;
                OPC_BRZ: begin o_class = CLS_BRANCH; o_cond_idx = COND_Z; end
                OPC_BRN: begin o_class = CLS_BRANCH; o_cond_idx = COND_N; end
                OPC_BRC: begin o_class = CLS_BRANCH; o_cond_idx = COND_C; end
                OPC_BRV: begin o_class = CLS_BRANCH; o_cond_idx = COND_V; end
                OPC_BRA: begin o_class = CLS_BRANCH; o_cond_always = 1'b1; end
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with bounded
// memory/ALU handshake waits that fault-halt on timeout.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    control_unit_if.slave  io_bus
);

    localparam int unsigned           CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    class_e              r_class;
    class_e              w_class;
    class_e              w_class_eff;
    logic [1:0]          r_cond_idx;
    logic [1:0]          w_cond_idx;
    logic                r_cond_always;
    logic                w_cond_always;
    logic                r_illegal;
    logic                w_illegal;
    logic                w_illegal_eff;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                w_waiting;
    logic                w_awaited;
    logic                w_timeout;
    strobe_t             r_strb;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic                r_halted;
    logic                r_fault;

    control_unit_opcode_classifier u_classifier (
        .i_opcode      (io_bus.opcode),
        .o_class       (w_class),
        .o_cond_idx    (w_cond_idx),
        .o_cond_always (w_cond_always),
        .o_illegal     (w_illegal)
    );

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM) || (r_state == ST_ALU_WAIT);
    assign w_awaited = (r_state == ST_ALU_WAIT) ? io_bus.alu_done : io_bus.mem_ready;
    assign w_timeout = w_waiting && !w_awaited && (r_wait_cnt == CNT_LAST);

    // Class latches at DECODE; the strobes for EXEC are registered on that same edge
    assign w_class_eff   = (r_state == ST_DECODE) ? w_class   : r_class;
    assign w_illegal_eff = (r_state == ST_DECODE) ? w_illegal : r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (io_bus.start) w_state_nxt = ST_FETCH;
            ST_FETCH:    if (io_bus.mem_ready) w_state_nxt = ST_IRLOAD;
            ST_IRLOAD:   w_state_nxt = ST_DECODE;
            ST_DECODE:   w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (r_class)
                    CLS_HLT:             w_state_nxt = ST_HALT;
                    CLS_BRANCH, CLS_NOP: w_state_nxt = ST_FETCH;
                    CLS_ALU:             w_state_nxt = ST_ALU_WAIT;
                    default:             w_state_nxt = ST_MEM;
                endcase
            end
            ST_MEM: begin
                if (io_bus.mem_ready)
                    w_state_nxt = (r_class == CLS_LDR || r_class == CLS_POP) ? ST_WB : ST_FETCH;
            end
            ST_ALU_WAIT: if (io_bus.alu_done) w_state_nxt = ST_WB;
            ST_WB:       w_state_nxt = ST_FETCH;
            default:     w_state_nxt = ST_HALT;
        endcase
        if (w_timeout) w_state_nxt = ST_HALT;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_class       <= CLS_NOP;
            r_cond_idx    <= COND_Z;
            r_cond_always <= 1'b0;
            r_illegal     <= 1'b0;
            r_wait_cnt    <= '0;
            r_strb        <= '0;
            r_alu_op      <= '0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) begin
                r_class       <= w_class;
                r_cond_idx    <= w_cond_idx;
                r_cond_always <= w_cond_always;
                r_illegal     <= w_illegal;
            end
            // Any state change clears the counter, so each wait state starts from zero
            if (w_state_nxt != r_state)
                r_wait_cnt <= '0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            r_strb   <= decode_strobes(w_state_nxt, w_class_eff, w_illegal_eff);
            r_alu_op <= (w_state_nxt == ST_EXEC || w_state_nxt == ST_ALU_WAIT)
                        ? io_bus.opcode[ALU_OP_W-1:0] : '0;
            if (w_state_nxt == ST_HALT) r_halted <= 1'b1;
            if (w_timeout)              r_fault  <= 1'b1;
        end
    end

    // Branch decision follows FLAGS live during EXEC
    assign io_bus.pc_load_c = (r_state == ST_EXEC) && (r_class == CLS_BRANCH)
                              && (r_cond_always || flag_sel(io_bus.flags, r_cond_idx));

    assign io_bus.ir_w      = r_strb.ir_w;
    assign io_bus.pc_inc    = r_strb.pc_inc;
    assign io_bus.addr_sel  = r_strb.addr_sel;
    assign io_bus.mem_rd    = r_strb.mem_rd;
    assign io_bus.mem_wr    = r_strb.mem_wr;
    assign io_bus.sp_inc    = r_strb.sp_inc;
    assign io_bus.sp_dec    = r_strb.sp_dec;
    assign io_bus.alu_start = r_strb.alu_start;
    assign io_bus.alu_op    = r_alu_op;
    assign io_bus.reg_w     = r_strb.reg_w;
    assign io_bus.wb_sel    = r_strb.wb_sel;
    assign io_bus.illegal   = r_strb.illegal;
    assign io_bus.halted    = r_halted;
    assign io_bus.fault     = r_fault;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: per-cycle expected strobe patterns per instruction.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit #(.WAIT_MAX(16)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Output vector: {ir_w,pc_inc,pc_load,addr_sel[1:0],mem_rd,mem_wr,sp_inc,sp_dec,alu_start,reg_w,wb_sel,illegal,halted,fault}
    wire [14:0] w_obs = {bus.ir_w, bus.pc_inc, bus.pc_load_c, bus.addr_sel, bus.mem_rd, bus.mem_wr,
                         bus.sp_inc, bus.sp_dec, bus.alu_start, bus.reg_w, bus.wb_sel,
                         bus.illegal, bus.halted, bus.fault};

    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] IRW  = 15'h4000;
    localparam logic [14:0] PCI  = 15'h2000;
    localparam logic [14:0] PCL  = 15'h1000;
    localparam logic [14:0] ASP  = 15'h0800;
    localparam logic [14:0] AIM  = 15'h0400;
    localparam logic [14:0] MRD  = 15'h0200;
    localparam logic [14:0] MWR  = 15'h0100;
    localparam logic [14:0] SPI  = 15'h0080;
    localparam logic [14:0] SPD  = 15'h0040;
    localparam logic [14:0] AST  = 15'h0020;
    localparam logic [14:0] RW   = 15'h0010;
    localparam logic [14:0] WBS  = 15'h0008;
    localparam logic [14:0] ILL  = 15'h0004;
    localparam logic [14:0] HLTD = 15'h0002;
    localparam logic [14:0] FLT  = 15'h0001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.opcode    = 6'h00;
        bus.flags     = 4'h0;
        bus.mem_ready = 1'b0;
        bus.alu_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({w_obs, bus.alu_op} !== 19'h0) begin
                errors++;
                $display("FAIL reset_idle c%0d got=%h want=0", i, {w_obs, bus.alu_op});
            end
        end
        bus.start = 1'b1;
        tick();
        checks++;
        if (w_obs !== MRD) begin
            errors++;
            $display("FAIL reset_start got=%h want=%h", w_obs, MRD);
        end
    endtask

    task automatic test_alu();
        logic [14:0] want [7];
        want = '{MRD, IRW | PCI, NONE, AST, NONE, RW, MRD};
        do_reset();
        bus.opcode = 6'b011010;
        bus.start  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.mem_ready = 1'b1;
            bus.alu_done  = (i == 4);
            checks++;
            if (w_obs !== want[i]) begin
                errors++;
                $display("FAIL alu c%0d got=%h want=%h", i + 1, w_obs, want[i]);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (bus.alu_op !== 4'hA) begin
                    errors++;
                    $display("FAIL alu_op c%0d got=%h want=a", i + 1, bus.alu_op);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] opc [8];
        logic [3:0] flg [8];
        logic       tkn [8];
        logic [14:0] want;
        opc = '{6'h05, 6'h05, 6'h06, 6'h06, 6'h07, 6'h08, 6'h08, 6'h09};
        flg = '{4'b1000, 4'b0000, 4'b0100, 4'b1011, 4'b0010, 4'b0001, 4'b1110, 4'b0000};
        tkn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            do_reset();
            bus.opcode    = opc[k];
            bus.flags     = flg[k];
            bus.mem_ready = 1'b1;
            bus.start     = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                case (i)
                    0:       want = MRD;
                    1:       want = IRW | PCI;
                    2:       want = NONE;
                    3:       want = tkn[k] ? PCL : NONE;
                    default: want = MRD;
                endcase
                checks++;
                if (w_obs !== want) begin
                    errors++;
                    $display("FAIL branch op=%h fl=%b c%0d got=%h want=%h", opc[k], flg[k], i + 1, w_obs, want);
                end
            end
        end
    endtask

    task automatic test_ldr_str();
        logic [14:0] w_str [6];
        logic [14:0] w_ldr [7];
        w_str = '{MRD, IRW | PCI, NONE, NONE, AIM | MWR, MRD};
        w_ldr = '{MRD, IRW | PCI, NONE, NONE, AIM | MRD, RW | WBS, MRD};
        do_reset();
        bus.opcode    = 6'h02;
        bus.mem_ready = 1'b1;
        bus.alu_done  = 1'b1;
        bus.start     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (w_obs !== w_str[i]) begin
                errors++;
                $display("FAIL str c%0d got=%h want=%h", i + 1, w_obs, w_str[i]);
            end
        end
        do_reset();
        bus.opcode    = 6'h01;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (w_obs !== w_ldr[i]) begin
                errors++;
                $display("FAIL ldr c%0d got=%h want=%h", i + 1, w_obs, w_ldr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] want [14];
        want = '{MRD, IRW | PCI, NONE, SPD, ASP | MWR, ASP | MWR, MRD,
                 IRW | PCI, NONE, NONE, ASP | MRD, ASP | MRD, RW | WBS | SPI, MRD};
        do_reset();
        bus.opcode = 6'h03;
        bus.start  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            bus.mem_ready = !(i == 4 || i == 10);
            if (i == 6) bus.opcode = 6'h04;
            checks++;
            if (w_obs !== want[i]) begin
                errors++;
                $display("FAIL psh_pop c%0d got=%h want=%h", i + 1, w_obs, want[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [14:0] want;
        do_reset();
        bus.opcode = 6'h01;
        bus.start  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            want = (i < 16) ? MRD : (HLTD | FLT);
            checks++;
            if (w_obs !== want) begin
                errors++;
                $display("FAIL timeout c%0d got=%h want=%h", i + 1, w_obs, want);
            end
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.start = (i != 1);
            tick();
            checks++;
            if (w_obs !== (HLTD | FLT)) begin
                errors++;
                $display("FAIL fault_sticky c%0d got=%h want=%h", i, w_obs, HLTD | FLT);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (w_obs !== NONE) begin
            errors++;
            $display("FAIL fault_clear got=%h want=0", w_obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_illegal_halt();
        logic [5:0]  opc [2];
        logic [14:0] w_ill [5];
        logic [14:0] w_hlt [6];
        opc   = '{6'h3F, 6'h0A};
        w_ill = '{MRD, IRW | PCI, NONE, ILL, MRD};
        w_hlt = '{MRD, IRW | PCI, NONE, NONE, HLTD, HLTD};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode    = opc[k];
            bus.mem_ready = 1'b1;
            bus.start     = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                checks++;
                if (w_obs !== w_ill[i]) begin
                    errors++;
                    $display("FAIL illegal op=%h c%0d got=%h want=%h", opc[k], i + 1, w_obs, w_ill[i]);
                end
            end
        end
        do_reset();
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (w_obs !== w_hlt[i]) begin
                errors++;
                $display("FAIL hlt c%0d got=%h want=%h", i + 1, w_obs, w_hlt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] want [5];
        want = '{MRD, IRW | PCI, NONE, AST, NONE};
        do_reset();
        bus.opcode    = 6'h13;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (w_obs !== want[i]) begin
                errors++;
                $display("FAIL alu_wait c%0d got=%h want=%h", i + 1, w_obs, want[i]);
            end
        end
        checks++;
        if (bus.alu_op !== 4'h3) begin
            errors++;
            $display("FAIL alu_wait_op got=%h want=3", bus.alu_op);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({w_obs, bus.alu_op} !== 19'h0) begin
            errors++;
            $display("FAIL reset_async got=%h want=0", {w_obs, bus.alu_op});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (w_obs !== MRD) begin
            errors++;
            $display("FAIL start_at_reset_release got=%h want=%h", w_obs, MRD);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_ldr_str();
        test_back_to_back();
        test_timeout();
        test_illegal_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
